// File: rtl/multiply_pkg.sv
// rtl/multiply_pkg.sv - shared constants and state type for the iterative multiplier
package multiply_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiply_if.sv
// rtl/multiply_if.sv - request/result bundle between a multiply client and the multiplier
interface multiply_if #(
    parameter int WIDTH = 32
);

    logic                 mult_begin;
    logic [WIDTH-1:0]     mult_op1;
    logic [WIDTH-1:0]     mult_op2;
    logic [2*WIDTH-1:0]   product;
    logic                 mult_end;

    modport master (
        output mult_begin,
        output mult_op1,
        output mult_op2,
        input  product,
        input  mult_end
    );

    modport slave (
        input  mult_begin,
        input  mult_op1,
        input  mult_op2,
        output product,
        output mult_end
    );

endinterface

// File: rtl/multiply_abs.sv
// rtl/multiply_abs.sv - two's complement magnitude and sign of one operand
module multiply_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign neg = val[WIDTH-1];
    assign mag = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/multiply.sv
// rtl/multiply.sv - radix-2 shift-add signed multiplier, WIDTH iterations per product
module multiply
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    multiply_if.slave  bus
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 sign;
    logic [2*WIDTH-1:0]   product_q;
    logic                 end_q;

    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 neg1;
    logic                 neg2;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;

    multiply_abs #(.WIDTH(WIDTH)) u_abs1 (
        .val (bus.mult_op1),
        .mag (mag1),
        .neg (neg1)
    );

    multiply_abs #(.WIDTH(WIDTH)) u_abs2 (
        .val (bus.mult_op2),
        .mag (mag2),
        .neg (neg2)
    );

    assign addend   = mplier[0] ? mcand : '0;
    assign acc_next = acc + addend;

    assign bus.product  = product_q;
    assign bus.mult_end = end_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            sign      <= 1'b0;
            product_q <= '0;
            end_q     <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.mult_begin) begin
                        mcand  <= {{WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        sign   <= neg1 ^ neg2;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    // Dropping the request abandons the operation; product is left untouched.
                    if (!bus.mult_begin) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            product_q <= sign ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
                            end_q     <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply.sv
// tb/tb_multiply.sv - directed self-checking bench for the iterative multiplier
module tb_multiply;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multiply_if #(.WIDTH(32)) bus ();

    multiply #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.mult_op1   = a;
        bus.mult_op2   = b;
        bus.mult_begin = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the start edge; expects mult_end exactly 32 edges later.
    task automatic wait_done(input logic [63:0] exp, input string tag, input bit scramble);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.mult_end === 1'b1) break;
            if (scramble && n == 5) begin
                bus.mult_op1 = 32'h1234_5678;
                bus.mult_op2 = 32'h8765_4321;
            end
        end
        check64({tag, "_latency"}, 64'(n), 64'd32);
        check64({tag, "_product"}, bus.product, exp);
    endtask

    task automatic drop();
        @(negedge clk);
        bus.mult_begin = 1'b0;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string tag);
        start(a, b);
        wait_done(exp, tag, 1'b0);
        drop();
    endtask

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.mult_begin = 1'b0;
        bus.mult_op1   = '0;
        bus.mult_op2   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("reset_product", bus.product, 64'd0);
        check64("reset_end", 64'(bus.mult_end), 64'd0);

        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mult_end !== 1'b0) seen = 1'b1;
        end
        check64("idle_no_end", 64'(seen), 64'd0);

        start(32'd3, 32'd5);
        wait_done(64'd15, "basic", 1'b0);
        start(-32'sd7, 32'd6);
        wait_done(64'hFFFF_FFFF_FFFF_FFD6, "b2b_neg_scrambled", 1'b1);
        drop();
        @(posedge clk);
        #1;
        check64("end_one_cycle", 64'(bus.mult_end), 64'd0);

        op(-32'sd7, -32'sd6, 64'd42, "neg_neg");
        op(32'd0, 32'hFFFF_FFFF, 64'd0, "zero_neg");
        op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min");
        op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "min_one");
        op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_max");

        start(32'd9, 32'd9);
        repeat (10) @(posedge clk);
        drop();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.mult_end !== 1'b0) seen = 1'b1;
        end
        check64("abort_no_end", 64'(seen), 64'd0);
        check64("abort_product_held", bus.product, 64'h3FFF_FFFF_0000_0001);
        op(32'd9, 32'd9, 64'd81, "restart");

        start(32'd5, 32'd7);
        repeat (16) @(posedge clk);
        #2;
        rst_n          = 1'b0;
        bus.mult_begin = 1'b0;
        #1;
        check64("midreset_product", bus.product, 64'd0);
        check64("midreset_end", 64'(bus.mult_end), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'd2, -32'sd3, 64'hFFFF_FFFF_FFFF_FFFA, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
